// File: rtl/scan_chain_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// scan_ctrl_pkg
// Shared encodings for the scan chain sequencer.
//   sc_op_t      : host command opcodes carried on cmd_op
//   sc_state_t   : sequencer states (also exported on the state_dbg port)
//   SC_MISR_POLY : feedback polynomial of the optional scan-out signature
//   sc_misr_next : one step of the 16-bit scan-out signature register
// -----------------------------------------------------------------------------
package scan_ctrl_pkg;

  typedef enum logic [1:0] {
    SC_OP_NOP     = 2'd0,
    SC_OP_FREEZE  = 2'd1,
    SC_OP_SHIFT   = 2'd2,
    SC_OP_RELEASE = 2'd3
  } sc_op_t;

  typedef enum logic [1:0] {
    SC_ST_FUNC  = 2'd0,
    SC_ST_HOLD  = 2'd1,
    SC_ST_SHIFT = 2'd2
  } sc_state_t;

  localparam logic [15:0] SC_MISR_POLY = 16'h1021;

  // Shift left, fold the outgoing MSB back through the polynomial, then
  // XOR in the (zero-extended) beat that just left the chain.
  function automatic logic [15:0] sc_misr_next(input logic [15:0] sig,
                                               input logic [15:0] din);
    return {sig[14:0], 1'b0} ^ (sig[15] ? SC_MISR_POLY : 16'h0000) ^ din;
  endfunction

endpackage

// File: rtl/scan_chain_ctrl_if.sv
// -----------------------------------------------------------------------------
// scan_chain_ctrl_if
// Host-side streams of the scan chain sequencer.
//   cmd_* : command channel (cmd_op, cmd_len) host -> sequencer
//   si_*  : scan-in beats host -> sequencer
//   so_*  : scan-out beats sequencer -> host
// Modports: master = host / testbench side, slave = sequencer side.
//
// Handshake rule for all three channels: a transfer happens on a rising CLK
// edge where valid and ready are both high. The source holds valid and its
// payload stable until that edge; ready may depend combinationally on valid.
// -----------------------------------------------------------------------------
interface scan_chain_ctrl_if #(
  parameter int SCAN_WIDTH = 1,
  parameter int LEN_W      = 16
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [LEN_W-1:0]      cmd_len;

  logic                  si_valid;
  logic                  si_ready;
  logic [SCAN_WIDTH-1:0] si_data;

  logic                  so_valid;
  logic                  so_ready;
  logic [SCAN_WIDTH-1:0] so_data;

  modport master (
    output cmd_valid, cmd_op, cmd_len, si_valid, si_data, so_ready,
    input  cmd_ready, si_ready, so_valid, so_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, si_valid, si_data, so_ready,
    output cmd_ready, si_ready, so_valid, so_data
  );

endinterface

// File: rtl/scan_chain_ctrl_out_buf.sv
// -----------------------------------------------------------------------------
// scan_out_buf
// One-entry skid register holding the beat most recently shifted out of the
// chain until the host takes it.
//   CLK, RST_N   : clock, asynchronous active-low reset
//   push         : a beat leaves the chain this cycle
//   push_data    : that beat
//   pop_ready    : host accepts the buffered beat
//   out_valid    : buffer holds a beat
//   out_data     : the buffered beat
//   can_push     : buffer is empty or is being drained this cycle
// A push in the same cycle as a pop replaces the entry, so a continuous
// stream moves one beat per cycle with no bubble.
// -----------------------------------------------------------------------------
module scan_out_buf #(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         can_push
);

  assign can_push = !out_valid || pop_ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (push) begin
      out_valid <= 1'b1;
      out_data  <= push_data;
    end else if (pop_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// -----------------------------------------------------------------------------
// scan_chain_ctrl
// Sequencer for a chain of scan cells. The host freezes the chain, shifts
// cmd_len beats through it (si stream in, so stream out) and releases it.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : cmd / si / so streams (scan_chain_ctrl_if.slave)
//   SCAN_IN    : to chain head, always equal to si_data
//   SCAN_OUT   : from chain tail
//   SCAN_MODE  : chain shift enable (high exactly on a firing beat)
//   SCAN_ANY   : chain held out of functional mode (state != FUNC)
//   busy       : a SHIFT command is in progress
//   done       : one-cycle pulse after the last beat of a SHIFT fires
//   state_dbg  : current sequencer state
//   sig        : 16-bit MISR over shifted-out beats, present only when
//                SCAN_CTRL_SIG_EN is defined (requires SCAN_WIDTH <= 16)
// -----------------------------------------------------------------------------
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int SCAN_WIDTH = 1,
  parameter int LEN_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  scan_chain_ctrl_if.slave      bus,
  output logic [SCAN_WIDTH-1:0] SCAN_IN,
  input  logic [SCAN_WIDTH-1:0] SCAN_OUT,
  output logic                  SCAN_MODE,
  output logic                  SCAN_ANY,
  output logic                  busy,
  output logic                  done,
  output sc_state_t             state_dbg
`ifdef SCAN_CTRL_SIG_EN
  ,
  output logic [15:0]           sig
`endif
);

  sc_state_t        state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             done_d;
  logic             cmd_fire;
  logic             fire;
  logic             so_can_push;

  // A beat moves only when the host offers one and the scan-out slot can
  // take the tail value the shift edge is about to overwrite.
  assign fire     = (state_q == SC_ST_SHIFT) && bus.si_valid && so_can_push;
  assign cmd_fire = bus.cmd_valid && bus.cmd_ready;

  assign bus.cmd_ready = (state_q != SC_ST_SHIFT);
  assign bus.si_ready  = fire;
  assign SCAN_MODE     = fire;
  assign SCAN_ANY      = (state_q != SC_ST_FUNC);
  assign SCAN_IN       = bus.si_data;
  assign busy          = (state_q == SC_ST_SHIFT);
  assign state_dbg     = state_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    // cmd_fire and fire are exclusive: commands are only taken outside SHIFT.
    if (cmd_fire) begin
      case (sc_op_t'(bus.cmd_op))
        SC_OP_FREEZE:  state_d = SC_ST_HOLD;
        SC_OP_RELEASE: state_d = SC_ST_FUNC;
        SC_OP_SHIFT: begin
          if (bus.cmd_len != '0) begin
            count_d = bus.cmd_len;
            state_d = SC_ST_SHIFT;
          end else begin
            state_d = SC_ST_HOLD;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (fire) begin
      count_d = count_q - LEN_W'(1);
      if (count_q == LEN_W'(1)) begin
        state_d = SC_ST_HOLD;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= SC_ST_FUNC;
      count_q <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done    <= done_d;
    end
  end

  scan_out_buf #(.W(SCAN_WIDTH)) u_so_buf (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (fire),
    .push_data (SCAN_OUT),
    .pop_ready (bus.so_ready),
    .out_valid (bus.so_valid),
    .out_data  (bus.so_data),
    .can_push  (so_can_push)
  );

`ifdef SCAN_CTRL_SIG_EN
  if (SCAN_WIDTH > 16) begin : g_sig_width_check
    $error("scan_chain_ctrl: SCAN_WIDTH must be <= 16 with SCAN_CTRL_SIG_EN");
  end

  // Signature restarts with every accepted SHIFT so it covers one pass only.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sig <= '0;
    end else if (cmd_fire && (bus.cmd_op == SC_OP_SHIFT)) begin
      sig <= '0;
    end else if (fire) begin
      sig <= sc_misr_next(sig, 16'(SCAN_OUT));
    end
  end
`endif

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Sequencer for a chain of ScanIn-style scan cells. Drives the chain's SCAN_ANY/SCAN_MODE/SCAN_IN and samples its SCAN_OUT.
- A host issues FREEZE / SHIFT / RELEASE commands. Scan data moves on valid/ready streams, one SCAN_WIDTH-bit beat per shift cycle.
- Sits between a debug/test host (JTAG-to-stream bridge or CSR block) and the scan cells.

Parameters:
- SCAN_WIDTH, 1, lanes per shift beat; must match the chain's SCAN_WIDTH.
- LEN_W, 16, width of the shift-length field and of the beat counter.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_op  in  2  0=NOP, 1=FREEZE, 2=SHIFT, 3=RELEASE.
- cmd_len  in  LEN_W  number of beats for SHIFT.
- si_valid  in  1  scan-in beat valid.
- si_ready  out  1  scan-in beat consumed.
- si_data  in  SCAN_WIDTH  beat to shift into the chain.
- so_valid  out  1  scan-out beat valid.
- so_ready  in  1  downstream accepts the scan-out beat.
- so_data  out  SCAN_WIDTH  beat shifted out of the chain.
- SCAN_IN  out  SCAN_WIDTH  to the chain head; equals si_data.
- SCAN_OUT  in  SCAN_WIDTH  from the chain tail.
- SCAN_MODE  out  1  chain shift enable.
- SCAN_ANY  out  1  chain out of functional mode.
- busy  out  1  state==SHIFT.
- done  out  1  one-cycle pulse when a SHIFT completes.

Behaviour:
- Clock and reset: CLK is the only clock; RST_N is the asynchronous, active-low reset.
- Reset values: state=FUNC, count=0, so_valid=0, so_data=0, done=0, cmd_ready=1, si_ready=0. SCAN_ANY and SCAN_MODE are 0 while RST_N is low.
- States: FUNC, HOLD, SHIFT.
- Chain controls, decoded from registered state plus the fire term:
  - SCAN_ANY = (state!=FUNC).
  - SCAN_MODE = fire.
  - fire = (state==SHIFT) & si_valid & (!so_valid | so_ready).
  - si_ready = fire.
- Chain response: in FUNC the chain loads functional data. In HOLD, or in SHIFT with fire=0, the chain freezes (SCAN_ANY=1, SCAN_MODE=0).
- cmd_ready = (state!=SHIFT). Commands are never accepted mid-shift.
- Transitions on an accepted command:
  - NOP: no state change.
  - FREEZE: go to HOLD.
  - RELEASE: go to FUNC.
  - SHIFT with cmd_len>0: count<=cmd_len, go to SHIFT.
  - SHIFT with cmd_len==0: go to HOLD with a done pulse the next cycle.
- SHIFT accepted from FUNC: the acceptance cycle is still functional (SCAN_ANY=0). The first shift beat can fire no earlier than the next cycle.
- Each fire:
  - so_data <= SCAN_OUT, sampled before the shift edge, i.e. the current tail value.
  - so_valid <= 1.
  - count <= count-1.
- When the firing beat has count==1: go to HOLD; done=1 the following cycle. The final so beat is valid in that same cycle.
- so_valid clears on so_ready when no fire occurs the same cycle. fire and so_ready in the same cycle replace the buffered beat with no bubble. Throughput is 1 beat/cycle.
- Backpressure: if si_valid=0 or the output buffer is blocked, the chain holds. No beat is lost or duplicated.
- After completion, state stays HOLD until RELEASE. The chain is never returned to functional mode automatically.
- Asynchronous reset mid-shift aborts: state goes to FUNC and the undelivered so beat is discarded. Chain contents are undefined.

Optional Feature:
- SCAN_CTRL_SIG_EN adds output port sig (16 bits), a MISR over shifted-out beats.
- Each fire: sig <= {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ zero-extended SCAN_OUT.
- sig clears to 0 on reset and on acceptance of a SHIFT command.
- SCAN_WIDTH must be ≤16; elaboration error otherwise.
- Without the macro there is no sig port and no MISR logic.

Decomposition:
- Package scan_ctrl_pkg holds:
  - op encodings SC_OP_NOP/FREEZE/SHIFT/RELEASE;
  - state encodings SC_ST_FUNC/HOLD/SHIFT;
  - SC_MISR_POLY=16'h1021.
- One sub-module, scan_out_buf: the 1-entry so skid register (valid/data, replace-on-simultaneous).

Test Plan:
- Reset with RST_N low mid-sim → SCAN_ANY=0, so_valid=0, cmd_ready=1 immediately, asynchronously.
- FREEZE, then RELEASE → SCAN_ANY 0→1 the cycle after FREEZE acceptance; SCAN_MODE stays 0; SCAN_ANY returns to 0 after RELEASE.
- SHIFT, SCAN_WIDTH=1, len=8, si stream 8'b1011_0010 into a model 8-deep ScanIn chain preloaded 8'hA5:
  - so delivers the A5 bits tail-first;
  - chain then holds the si pattern;
  - exactly one done pulse;
  - state HOLD.
- Same shift with si_valid toggling and so_ready low for 3 cycles:
  - fire suppressed during stalls;
  - 8 so beats total, in order;
  - chain contents identical to the no-stall run.
- SHIFT with len=0 → no fire, done pulse, state HOLD.
- SCAN_CTRL_SIG_EN, SCAN_WIDTH=4, shifting out beats 1,2,3 → sig matches a reference MISR computation, e.g. after beat 1 sig=16'h0001 and after beat 2 sig=16'h0000.
